// File: rtl/keypad_scan_unit.sv
// 4x4 active-low matrix keypad scanner: row scan, press/release debounce, hex code with strobe.
// Optional feature macro: KEYPAD_REPEAT_EN adds auto-repeat strobes while a key stays held.
module keypad_scan_unit #(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned DEBOUNCE_CNT = 10,
    parameter int unsigned REPEAT_DLY   = 25000000,
    parameter int unsigned REPEAT_RATE  = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DEB_W = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT - 1);

    // Elaboration-time parameter sanity checks; they produce no hardware.
    if (SCAN_DIV < 2) begin : g_chk_scan_div
        $error("keypad_scan_unit: SCAN_DIV must be at least 2");
    end
    if (DEBOUNCE_CNT < 1) begin : g_chk_debounce
        $error("keypad_scan_unit: DEBOUNCE_CNT must be at least 1");
    end
    if (REPEAT_DLY < 1 || REPEAT_RATE < 1) begin : g_chk_repeat
        $error("keypad_scan_unit: REPEAT_DLY and REPEAT_RATE must be at least 1");
    end

    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StPressed,
        StRelease
    } state_e;

    state_e           state;
    logic [1:0]       row_idx;
    logic [DIV_W-1:0] div_cnt;
    logic [DEB_W-1:0] deb_cnt;
    logic [3:0]       pat;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int unsigned RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam logic [RPT_W-1:0] RPT_DLY_LAST  = RPT_W'(REPEAT_DLY - 1);
    localparam logic [RPT_W-1:0] RPT_RATE_LAST = RPT_W'(REPEAT_RATE - 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_first;
    logic [RPT_W-1:0] rpt_limit;

    assign rpt_limit = rpt_first ? RPT_DLY_LAST : RPT_RATE_LAST;
`endif

    logic [3:0] col_n;
    logic       col_idle;
    logic       col_single;
    logic       col_match;

    always_comb begin
        col_n      = ~col;
        col_idle   = (col == 4'hF);
        // Exactly one low column: non-zero and a power of two after inversion.
        col_single = !col_idle && ((col_n & (col_n - 4'd1)) == 4'h0);
        col_match  = (col == pat);
    end

    function automatic logic [1:0] col_index(input logic [3:0] p);
        if (!p[0]) return 2'd0;
        if (!p[1]) return 2'd1;
        if (!p[2]) return 2'd2;
        return 2'd3;
    endfunction

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        unique case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StScan;
            row       <= 4'b1110;
            row_idx   <= 2'd0;
            div_cnt   <= '0;
            deb_cnt   <= '0;
            pat       <= 4'hF;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
`endif
        end else begin
            key_valid <= 1'b0;
            unique case (state)
                StScan: begin
                    if (div_cnt == DIV_LAST) begin
                        if (col_single) begin
                            // Row stays frozen on the candidate key while it debounces.
                            pat     <= col;
                            deb_cnt <= '0;
                            state   <= StDebounce;
                        end else begin
                            row     <= {row[2:0], row[3]};
                            row_idx <= row_idx + 2'd1;
                            div_cnt <= '0;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                StDebounce: begin
                    if (col_match) begin
                        if (deb_cnt == DEB_LAST) begin
                            state     <= StPressed;
                            key_code  <= key_map(row_idx, col_index(pat));
                            key_valid <= 1'b1;
                            key_held  <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                            rpt_cnt   <= '0;
                            rpt_first <= 1'b1;
`endif
                        end else begin
                            deb_cnt <= deb_cnt + DEB_W'(1);
                        end
                    end else begin
                        state   <= StScan;
                        row     <= {row[2:0], row[3]};
                        row_idx <= row_idx + 2'd1;
                        div_cnt <= '0;
                    end
                end

                StPressed: begin
                    if (col_idle) begin
                        state   <= StRelease;
                        deb_cnt <= '0;
                    end else begin
`ifdef KEYPAD_REPEAT_EN
                        if (rpt_cnt == rpt_limit) begin
                            key_valid <= 1'b1;
                            rpt_cnt   <= '0;
                            rpt_first <= 1'b0;
                        end else begin
                            rpt_cnt <= rpt_cnt + RPT_W'(1);
                        end
`endif
                    end
                end

                StRelease: begin
                    if (col_idle) begin
                        if (deb_cnt == DEB_LAST) begin
                            state    <= StScan;
                            key_held <= 1'b0;
                            row      <= {row[2:0], row[3]};
                            row_idx  <= row_idx + 2'd1;
                            div_cnt  <= '0;
                        end else begin
                            deb_cnt <= deb_cnt + DEB_W'(1);
                        end
                    end else begin
                        // Contact bounce on release: still the same press, no new strobe.
                        state <= StPressed;
`ifdef KEYPAD_REPEAT_EN
                        rpt_cnt   <= '0;
                        rpt_first <= 1'b1;
`endif
                    end
                end

                default: state <= StScan;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan_unit.sv
// Randomised bench for keypad_scan_unit: a simulated key matrix drives col, a behavioural model
// predicts row, key_code, key_valid and key_held every cycle.
module tb_keypad_scan_unit;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEB      = 3;
    localparam int unsigned RDLY     = 20;
    localparam int unsigned RRATE    = 8;
`ifdef KEYPAD_REPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    localparam int M_SCAN = 0;
    localparam int M_DEB  = 1;
    localparam int M_PRS  = 2;
    localparam int M_REL  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int valid_cnt = 0;

    always #5 clk = ~clk;

    keypad_scan_unit #(
        .SCAN_DIV    (SCAN_DIV),
        .DEBOUNCE_CNT(DEB),
        .REPEAT_DLY  (RDLY),
        .REPEAT_RATE (RRATE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .col      (col),
        .row      (row),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Keypad: pressed[r*4+c] set means the key at row r, column c is down.
    logic [15:0] pressed;
    bit          bounce_en;
    bit          bounce_ph;
    logic [3:0]  keymap [16];

    // Behavioural model state.
    int         m_mode;
    int         m_row;
    int         m_tick;
    int         m_run;
    int         m_rep;
    bit         m_rep_first;
    logic [3:0] m_pat;
    logic [3:0] m_code;
    bit         m_valid;
    bit         m_held;

    task automatic model_reset();
        m_mode = M_SCAN; m_row = 0; m_tick = 0; m_run = 0; m_rep = 0; m_rep_first = 1'b1;
        m_pat = 4'hF; m_code = 4'h0; m_valid = 1'b0; m_held = 1'b0;
    endtask

    task automatic next_row();
        m_row  = (m_row + 1) % 4;
        m_tick = 0;
    endtask

    task automatic model_step(input logic [3:0] c);
        logic [3:0] inv;
        int ci;
        m_valid = 1'b0;
        inv = ~c;
        case (m_mode)
            M_SCAN: begin
                if (m_tick == SCAN_DIV - 1) begin
                    if ($countones(inv) == 1) begin
                        m_pat = c; m_run = 0; m_mode = M_DEB;
                    end else begin
                        next_row();
                    end
                end else begin
                    m_tick++;
                end
            end
            M_DEB: begin
                if (c == m_pat) begin
                    m_run++;
                    if (m_run == DEB) begin
                        ci = 0;
                        for (int j = 3; j >= 0; j--) if (!m_pat[j]) ci = j;
                        m_code = keymap[m_row * 4 + ci];
                        m_mode = M_PRS; m_valid = 1'b1; m_held = 1'b1;
                        m_rep = 0; m_rep_first = 1'b1;
                    end
                end else begin
                    m_mode = M_SCAN;
                    next_row();
                end
            end
            M_PRS: begin
                if (c == 4'hF) begin
                    m_mode = M_REL; m_run = 0;
                end else if (REPEAT_ON) begin
                    m_rep++;
                    if (m_rep == (m_rep_first ? RDLY : RRATE)) begin
                        m_valid = 1'b1; m_rep = 0; m_rep_first = 1'b0;
                    end
                end
            end
            default: begin
                if (c == 4'hF) begin
                    m_run++;
                    if (m_run == DEB) begin
                        m_held = 1'b0; m_mode = M_SCAN;
                        next_row();
                    end
                end else begin
                    m_mode = M_PRS; m_rep = 0; m_rep_first = 1'b1;
                end
            end
        endcase
    endtask

    task automatic drive_col();
        if (bounce_en) begin
            bounce_ph = ~bounce_ph;
            col = bounce_ph ? 4'b1110 : 4'b1111;
        end else begin
            for (int j = 0; j < 4; j++) col[j] = ~pressed[m_row * 4 + j];
        end
    endtask

    task automatic set_keys(input logic [15:0] mask);
        pressed = mask;
        drive_col();
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic cycle();
        logic [3:0] exp_row;
        @(posedge clk);
        model_step(col);
        @(negedge clk);
        cyc++;
        exp_row = ~(4'b0001 << m_row);
        check("row", row, exp_row);
        check("key_valid", key_valid, m_valid);
        check("key_held", key_held, m_held);
        check("key_code", key_code, m_code);
        if (key_valid) valid_cnt++;
        drive_col();
    endtask

    task automatic wait_held(input logic want, input string tag);
        int n = 0;
        while (key_held !== want && n < 200) begin
            cycle();
            n++;
        end
        check(tag, key_held, want);
    endtask

    task automatic wait_mode(input int want, input string tag);
        int n = 0;
        while (m_mode != want && n < 200) begin
            cycle();
            n++;
        end
        check(tag, m_mode, want);
    endtask

    // Asynchronous reset pulse between clock edges; outputs must drop without a clock.
    task automatic reset_mid(input string tag);
        rst = 1'b1;
        #1;
        check({tag, "_row"}, row, 4'b1110);
        check({tag, "_code"}, key_code, 4'h0);
        check({tag, "_valid"}, key_valid, 1'b0);
        check({tag, "_held"}, key_held, 1'b0);
        #1;
        rst = 1'b0;
        model_reset();
        drive_col();
    endtask

    initial begin
        int a;
        int offs[$];
        int exp_offs[$];
        keymap = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                   4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
        rst = 1'b1;
        pressed = '0;
        bounce_en = 1'b0;
        bounce_ph = 1'b0;
        model_reset();
        drive_col();
        repeat (2) @(negedge clk);
        check("rst_row", row, 4'b1110);
        check("rst_code", key_code, 4'h0);
        check("rst_valid", key_valid, 1'b0);
        check("rst_held", key_held, 1'b0);
        rst = 1'b0;

        // Idle scan.
        valid_cnt = 0;
        repeat (40) cycle();
        check("idle_pulses", valid_cnt, 0);

        // Key 6 (row 1, col 2), then release.
        valid_cnt = 0;
        set_keys(16'h1 << 6);
        wait_held(1'b1, "k6_accept");
        repeat (6) cycle();
        check("k6_code", key_code, 4'h6);
        check("k6_pulses", valid_cnt, 1);
        set_keys(16'h0);
        wait_held(1'b0, "k6_release");
        check("k6_resume_row", row, 4'b1011);

        // Bounce during debounce.
        set_keys(16'h1);
        wait_mode(M_DEB, "bounce_enter");
        valid_cnt = 0;
        bounce_en = 1'b1;
        repeat (12) cycle();
        bounce_en = 1'b0;
        set_keys(16'h0);
        repeat (8) cycle();
        check("bounce_pulses", valid_cnt, 0);
        check("bounce_held", key_held, 1'b0);

        // Two columns low in one row are ignored; then key 0 (row 3, col 1).
        valid_cnt = 0;
        set_keys(16'h0003);
        repeat (24) cycle();
        check("multi_pulses", valid_cnt, 0);
        set_keys(16'h1 << 13);
        wait_held(1'b1, "k0_accept");
        check("k0_code", key_code, 4'h0);
        check("k0_pulses", valid_cnt, 1);
        set_keys(16'h0);
        wait_held(1'b0, "k0_release");

        // Reset in DEBOUNCE and in PRESSED; the held key is re-detected afterwards.
        set_keys(16'h1 << 8);
        wait_mode(M_DEB, "rst_deb_enter");
        reset_mid("rst_deb");
        wait_held(1'b1, "k7_accept");
        reset_mid("rst_prs");
        wait_held(1'b1, "k7_redetect");
        check("k7_code", key_code, 4'h7);
        set_keys(16'h0);
        wait_held(1'b0, "k7_release");

        // Hold key A for 50 clocks after accept.
        set_keys(16'h1 << 3);
        a = 0;
        while (!key_valid && a < 200) begin
            cycle();
            a++;
        end
        check("kA_accept", key_valid, 1'b1);
        check("kA_code", key_code, 4'hA);
        a = cyc;
        repeat (50) begin
            cycle();
            if (key_valid) offs.push_back(cyc - a);
        end
`ifdef KEYPAD_REPEAT_EN
        exp_offs = '{20, 28, 36, 44};
`endif
        check("kA_repeats", offs.size(), exp_offs.size());
        for (int i = 0; i < offs.size() && i < exp_offs.size(); i++)
            check("kA_offset", offs[i], exp_offs[i]);
        set_keys(16'h0);
        wait_held(1'b0, "kA_release");

        // Random presses, holds, bounces and resets.
        repeat (40) begin
            int r;
            logic [15:0] m;
            r = $urandom_range(0, 9);
            m = '0;
            if (r < 7) begin
                m[$urandom_range(0, 15)] = 1'b1;
            end else if (r < 9) begin
                m[$urandom_range(0, 15)] = 1'b1;
                m[$urandom_range(0, 15)] = 1'b1;
            end
            set_keys(m);
            repeat ($urandom_range(0, 40)) cycle();
            if ($urandom_range(0, 3) == 0) begin
                bounce_en = 1'b1;
                repeat ($urandom_range(1, 6)) cycle();
                bounce_en = 1'b0;
            end
            if ($urandom_range(0, 15) == 0) reset_mid("rnd_rst");
            set_keys(16'h0);
            repeat ($urandom_range(0, 25)) cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
